sbox_arbiter: RTL and testbench
===============================

SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 Parameter: WORD_WIDTH, 32, width of request/response words (4 bytes).
REQ-002 Parameter: CNT_WIDTH, 8, width of contention counter.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: sbox_available  input  1  S-box LUT loaded and usable.
REQ-006 Port: ke_req_vld / ke_req_data  input  1 / WORD_WIDTH  key-expansion substitution request.
REQ-007 Port: ke_req_rdy  output  1  key-expansion request accepted this cycle.
REQ-008 Port: sb_req_vld / sb_req_data  input  1 / WORD_WIDTH  sub-bytes substitution request.
REQ-009 Port: sb_req_rdy  output  1  sub-bytes request accepted this cycle.
REQ-010 Port: lut_in / lut_in_vld  output  WORD_WIDTH / 1  word driven to shared combinational S-box LUT.
REQ-011 Port: lut_out  input  WORD_WIDTH  combinational substituted word returned by LUT.
REQ-012 Port: ke_rsp / ke_rsp_vld  output  WORD_WIDTH / 1  registered result to key expansion.
REQ-013 Port: sb_rsp / sb_rsp_vld  output  WORD_WIDTH / 1  registered result to sub-bytes path.
REQ-014 Port: contention_cnt  output  CNT_WIDTH  saturating count of cycles with both requests valid while RUN.

Function
REQ-015 FSM states: IDLE, RUN; IDLE->RUN when sbox_available=1; RUN->IDLE when sbox_available=0; transition takes effect next cycle.
REQ-016 IDLE: ke_req_rdy=sb_req_rdy=0, lut_in_vld=0, no grants.
REQ-017 RUN: at most one grant per cycle; grant = rdy asserted combinationally in same cycle as that requester's vld.
REQ-018 Single requester valid in RUN -> granted immediately.
REQ-019 Both valid in RUN -> round-robin: grant the requester not granted in the last contested cycle; last_grant flag updates only on contested cycles.
REQ-020 Requester holds vld and data stable until rdy; arbiter never grants a non-valid requester.
REQ-021 On grant: lut_in = granted data, lut_in_vld=1; otherwise lut_in=0, lut_in_vld=0.
REQ-022 Latency 1: cycle after grant, lut_out captured into granted requester's rsp register and its rsp_vld pulses high exactly one cycle; other rsp_vld=0.
REQ-023 Responses have no backpressure; rsp data holds last value until next response to that requester.
REQ-024 Back-to-back grants permitted every cycle; throughput one word/cycle total.
REQ-025 sbox_available falling while a grant is in flight: in-flight response still delivered next cycle; no new grants.
REQ-026 contention_cnt increments by 1 each RUN cycle with ke_req_vld=sb_req_vld=1; saturates at 2^CNT_WIDTH-1, no wrap.

Reset
REQ-027 reset=0 asynchronously forces: state IDLE, all rdy/vld outputs 0, ke_rsp=sb_rsp=0, lut_in=0, contention_cnt=0, last_grant=sub-bytes (so key expansion wins first contest).
REQ-028 Reset asserted mid-operation discards any in-flight response; no rsp_vld after reset release until a new grant.
REQ-029 After reset release, first grant possible no earlier than the cycle after sbox_available is sampled high.

Verification
REQ-030 sbox_available=0, both vld=1 for 5 cycles -> both rdy=0, no rsp_vld, contention_cnt=0.
REQ-031 RUN, ke only, ke_req_data=0x00010203 -> ke_req_rdy=1 same cycle, lut_in=0x00010203; next cycle ke_rsp=lut_out (0x637C777B with standard S-box), ke_rsp_vld=1 one cycle.
REQ-032 RUN, both vld held 4 cycles after reset -> grants ke, sb, ke, sb; responses alternate one cycle later; contention_cnt=4.
REQ-033 Both vld held 300 cycles -> contention_cnt saturates at 255.
REQ-034 sb granted, sbox_available drops same cycle -> sb_rsp_vld=1 next cycle, then no grants while IDLE.
REQ-035 Reset pulsed low the cycle after a grant -> no rsp_vld, all outputs 0, contention_cnt=0.

Source files
------------

// File: rtl/sbox_arbiter.sv
// Round-robin arbiter sharing one combinational S-box LUT between the key-expansion
// and sub-bytes requesters, with registered one-cycle-latency responses.
module sbox_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sbox_available,
    input  logic                  ke_req_vld,
    input  logic [WORD_WIDTH-1:0] ke_req_data,
    output logic                  ke_req_rdy,
    input  logic                  sb_req_vld,
    input  logic [WORD_WIDTH-1:0] sb_req_data,
    output logic                  sb_req_rdy,
    output logic [WORD_WIDTH-1:0] lut_in,
    output logic                  lut_in_vld,
    input  logic [WORD_WIDTH-1:0] lut_out,
    output logic [WORD_WIDTH-1:0] ke_rsp,
    output logic                  ke_rsp_vld,
    output logic [WORD_WIDTH-1:0] sb_rsp,
    output logic                  sb_rsp_vld,
    output logic [CNT_WIDTH-1:0]  contention_cnt
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state_q, state_d;
    logic   last_grant_ke_q;
    logic   grant_ke, grant_sb, contested;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Contested cycles alternate; the reset value of last_grant_ke_q lets key expansion win first.
    always_comb begin
        state_d   = state_q;
        grant_ke  = 1'b0;
        grant_sb  = 1'b0;
        contested = 1'b0;
        case (state_q)
            IDLE: begin
                if (sbox_available) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!sbox_available) begin
                    state_d = IDLE;
                end
                contested = ke_req_vld && sb_req_vld;
                if (contested) begin
                    grant_ke = !last_grant_ke_q;
                    grant_sb = last_grant_ke_q;
                end else begin
                    grant_ke = ke_req_vld;
                    grant_sb = sb_req_vld;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ke_req_rdy = grant_ke;
    assign sb_req_rdy = grant_sb;
    assign lut_in_vld = grant_ke || grant_sb;
    assign lut_in     = grant_ke ? ke_req_data :
                        grant_sb ? sb_req_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ke_rsp          <= '0;
            ke_rsp_vld      <= 1'b0;
            sb_rsp          <= '0;
            sb_rsp_vld      <= 1'b0;
            last_grant_ke_q <= 1'b0;
            contention_cnt  <= '0;
        end else begin
            ke_rsp_vld <= grant_ke;
            sb_rsp_vld <= grant_sb;
            if (grant_ke) begin
                ke_rsp <= lut_out;
            end
            if (grant_sb) begin
                sb_rsp <= lut_out;
            end
            if (contested) begin
                last_grant_ke_q <= grant_ke;
                if (contention_cnt != CNT_MAX) begin
                    contention_cnt <= contention_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter; the shared LUT is modelled with the AES S-box table.
module tb_sbox_arbiter;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [31:0] KE_WORD = 32'h0001_0203;
    localparam logic [31:0] KE_SUB  = 32'h637C_777B;
    localparam logic [31:0] SB_WORD = 32'h1020_3040;
    localparam logic [31:0] SB_SUB  = 32'hCAB7_0409;
    localparam logic [31:0] SB_WORD2 = 32'h4030_2010;
    localparam logic [31:0] SB_SUB2  = 32'h0904_B7CA;

    logic        clk;
    logic        reset;
    logic        sbox_available;
    logic        ke_req_vld, sb_req_vld;
    logic [31:0] ke_req_data, sb_req_data;
    logic        ke_req_rdy, sb_req_rdy;
    logic [31:0] lut_in, lut_out;
    logic        lut_in_vld;
    logic [31:0] ke_rsp, sb_rsp;
    logic        ke_rsp_vld, sb_rsp_vld;
    logic [7:0]  contention_cnt;

    int checkCount = 0;
    int errorCount = 0;

    sbox_arbiter #(.WORD_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .sbox_available (sbox_available),
        .ke_req_vld     (ke_req_vld),
        .ke_req_data    (ke_req_data),
        .ke_req_rdy     (ke_req_rdy),
        .sb_req_vld     (sb_req_vld),
        .sb_req_data    (sb_req_data),
        .sb_req_rdy     (sb_req_rdy),
        .lut_in         (lut_in),
        .lut_in_vld     (lut_in_vld),
        .lut_out        (lut_out),
        .ke_rsp         (ke_rsp),
        .ke_rsp_vld     (ke_rsp_vld),
        .sb_rsp         (sb_rsp),
        .sb_rsp_vld     (sb_rsp_vld),
        .contention_cnt (contention_cnt)
    );

    assign lut_out = {SBOX[lut_in[31:24]], SBOX[lut_in[23:16]], SBOX[lut_in[15:8]], SBOX[lut_in[7:0]]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic keVld, input logic [31:0] keData,
                                 input logic sbVld, input logic [31:0] sbData, input logic avail);
        ke_req_vld     = keVld;
        ke_req_data    = keData;
        sb_req_vld     = sbVld;
        sb_req_data    = sbData;
        sbox_available = avail;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ke_rdy"}, {31'b0, ke_req_rdy}, 32'd0);
        checkOutput({tag, "_sb_rdy"}, {31'b0, sb_req_rdy}, 32'd0);
        checkOutput({tag, "_lut_vld"}, {31'b0, lut_in_vld}, 32'd0);
        checkOutput({tag, "_lut_in"}, lut_in, 32'd0);
        checkOutput({tag, "_ke_rsp_vld"}, {31'b0, ke_rsp_vld}, 32'd0);
        checkOutput({tag, "_sb_rsp_vld"}, {31'b0, sb_rsp_vld}, 32'd0);
        checkOutput({tag, "_ke_rsp"}, ke_rsp, 32'd0);
        checkOutput({tag, "_sb_rsp"}, sb_rsp, 32'd0);
        checkOutput({tag, "_cnt"}, {24'b0, contention_cnt}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b1, KE_WORD, 1'b1, SB_WORD, 1'b0);
        #3;
        checkAllZero("reset");
        stepClock();
        stepClock();
        reset = 1'b1;

        // S-box unavailable: requests are ignored and nothing is counted
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("unavail_ke_rdy", {31'b0, ke_req_rdy}, 32'd0);
            checkOutput("unavail_sb_rdy", {31'b0, sb_req_rdy}, 32'd0);
            checkOutput("unavail_rsp_vld", {30'b0, ke_rsp_vld, sb_rsp_vld}, 32'd0);
            stepClock();
        end
        checkOutput("unavail_cnt", {24'b0, contention_cnt}, 32'd0);

        // Single key-expansion request
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, KE_WORD, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("single_ke_rdy", {31'b0, ke_req_rdy}, 32'd1);
        checkOutput("single_sb_rdy", {31'b0, sb_req_rdy}, 32'd0);
        checkOutput("single_lut_in", lut_in, KE_WORD);
        checkOutput("single_lut_vld", {31'b0, lut_in_vld}, 32'd1);
        stepClock();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("single_ke_rsp_vld", {31'b0, ke_rsp_vld}, 32'd1);
        checkOutput("single_ke_rsp", ke_rsp, KE_SUB);
        checkOutput("single_sb_rsp_vld", {31'b0, sb_rsp_vld}, 32'd0);
        checkOutput("idle_lut_in", lut_in, 32'd0);
        stepClock();
        checkOutput("single_ke_rsp_pulse", {31'b0, ke_rsp_vld}, 32'd0);
        checkOutput("single_ke_rsp_hold", ke_rsp, KE_SUB);
        checkOutput("single_cnt", {24'b0, contention_cnt}, 32'd0);

        // Contested requests alternate ke, sb, ke, sb
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, KE_WORD, 1'b1, SB_WORD, 1'b1);
            #1;
            checkOutput("rr_ke_rdy", {31'b0, ke_req_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_sb_rdy", {31'b0, sb_req_rdy}, (i % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("rr_lut_in", lut_in, (i % 2 == 0) ? KE_WORD : SB_WORD);
            if (i > 0) begin
                checkOutput("rr_ke_rsp_vld", {31'b0, ke_rsp_vld}, (i % 2 == 1) ? 32'd1 : 32'd0);
                checkOutput("rr_sb_rsp_vld", {31'b0, sb_rsp_vld}, (i % 2 == 0) ? 32'd1 : 32'd0);
            end
            stepClock();
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("rr_last_sb_rsp_vld", {31'b0, sb_rsp_vld}, 32'd1);
        checkOutput("rr_last_sb_rsp", sb_rsp, SB_SUB);
        checkOutput("rr_cnt", {24'b0, contention_cnt}, 32'd4);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, KE_WORD, 1'b1, SB_WORD, 1'b1);
            stepClock();
            if (i == 99) begin
                checkOutput("cnt_mid", {24'b0, contention_cnt}, 32'd104);
            end
        end
        checkOutput("cnt_saturated", {24'b0, contention_cnt}, 32'd255);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        stepClock();

        // sb granted in the same cycle sbox_available falls
        applyStimulus(1'b0, 32'd0, 1'b1, SB_WORD2, 1'b0);
        #1;
        checkOutput("drop_sb_rdy", {31'b0, sb_req_rdy}, 32'd1);
        checkOutput("drop_lut_in", lut_in, SB_WORD2);
        stepClock();
        applyStimulus(1'b1, KE_WORD, 1'b1, SB_WORD, 1'b0);
        #1;
        checkOutput("drop_sb_rsp_vld", {31'b0, sb_rsp_vld}, 32'd1);
        checkOutput("drop_sb_rsp", sb_rsp, SB_SUB2);
        checkOutput("drop_no_grant", {30'b0, ke_req_rdy, sb_req_rdy}, 32'd0);
        checkOutput("drop_lut_vld", {31'b0, lut_in_vld}, 32'd0);
        stepClock();
        checkOutput("drop_rsp_vld_after", {30'b0, ke_rsp_vld, sb_rsp_vld}, 32'd0);
        checkOutput("drop_cnt", {24'b0, contention_cnt}, 32'd255);

        // Reset right after a grant discards the in-flight response
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, KE_WORD, 1'b1, SB_WORD, 1'b1);
        #1;
        checkOutput("pre_reset_ke_rdy", {31'b0, ke_req_rdy}, 32'd1);
        stepClock();
        #1;
        checkOutput("pre_reset_sb_rdy", {31'b0, sb_req_rdy}, 32'd1);
        reset = 1'b0;
        #1;
        checkAllZero("mid_reset");
        stepClock();
        checkAllZero("held_reset");
        reset = 1'b1;
        #1;
        checkOutput("post_reset_idle_rdy", {30'b0, ke_req_rdy, sb_req_rdy}, 32'd0);
        stepClock();
        #1;
        checkOutput("post_reset_ke_first", {31'b0, ke_req_rdy}, 32'd1);
        checkOutput("post_reset_sb_wait", {31'b0, sb_req_rdy}, 32'd0);
        checkOutput("post_reset_no_rsp", {30'b0, ke_rsp_vld, sb_rsp_vld}, 32'd0);
        stepClock();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("post_reset_ke_rsp_vld", {31'b0, ke_rsp_vld}, 32'd1);
        checkOutput("post_reset_ke_rsp", ke_rsp, KE_SUB);
        checkOutput("post_reset_cnt", {24'b0, contention_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
